// File: rtl/b_ext_pipe.sv
// Two-stage execute unit for the unary Zbb ops cpop(w), clz(w), ctz(w), orc.b and rev8.
// Stage 1 captures the op; stage 2 holds the registered result that drives the outputs.
module b_ext_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             vld_p1;
    logic [2:0]       op_p1;
    logic [WIDTH-1:0] a_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [WIDTH-1:0] res_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] res_p2;
    logic [TAG_W-1:0] tag_p2;

    logic s2_accept;
    logic s1_adv;

    function automatic logic [6:0] popcnt64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

    // Word forms reuse these by padding the unused half with ones, so an
    // all-zero low word naturally counts to 32.
    function automatic logic [6:0] clz64(input logic [63:0] v);
        logic [6:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) hit = 1'b1;
            else if (!hit) n = n + 7'd1;
        end
        return n;
    endfunction

    function automatic logic [6:0] ctz64(input logic [63:0] v);
        logic [6:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) hit = 1'b1;
            else if (!hit) n = n + 7'd1;
        end
        return n;
    endfunction

    function automatic logic [63:0] orc_b(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{|v[8*i +: 8]}};
        return r;
    endfunction

    function automatic logic [63:0] rev8(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
        return r;
    endfunction

    assign s2_accept = !vld_p2 || out_ready;
    assign s1_adv    = vld_p1 && s2_accept;
    assign in_ready  = !vld_p1 || s1_adv;

    assign out_valid  = vld_p2;
    assign out_result = res_p2;
    assign out_tag    = tag_p2;
    assign busy       = vld_p1 || vld_p2;

    // Stage 1 -> stage 2: compute from the captured op
    always_comb begin
        res_p1 = '0;
        unique case (op_p1)
            3'b000: res_p1 = WIDTH'(popcnt64(a_p1));
            3'b001: res_p1 = WIDTH'(popcnt64({32'd0, a_p1[31:0]}));
            3'b010: res_p1 = WIDTH'(clz64(a_p1));
            3'b011: res_p1 = WIDTH'(clz64({a_p1[31:0], 32'hFFFF_FFFF}));
            3'b100: res_p1 = WIDTH'(ctz64(a_p1));
            3'b101: res_p1 = WIDTH'(ctz64({32'hFFFF_FFFF, a_p1[31:0]}));
            3'b110: res_p1 = orc_b(a_p1);
            3'b111: res_p1 = rev8(a_p1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            op_p1  <= '0;
            a_p1   <= '0;
            tag_p1 <= '0;
            res_p2 <= '0;
            tag_p2 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            // Input -> stage 1
            if (in_ready) vld_p1 <= in_valid;
            if (in_valid && in_ready) begin
                op_p1  <= in_op;
                a_p1   <= in_a;
                tag_p1 <= in_tag;
            end
            // Stage 1 -> stage 2
            if (s2_accept) vld_p2 <= vld_p1;
            if (s1_adv) begin
                res_p2 <= res_p1;
                tag_p2 <= tag_p1;
            end
        end
    end

endmodule
